spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI master sequencer behind the memory-mapped SPI registers of the rv32 I/O block. It takes the SPI output word and clock-divider value written by the CPU and drives the external bus:
- generates SCLK in mode 0 (CPOL=0, CPHA=0);
- shifts MOSI and samples MISO, MSB first;
- frames the transfer with an active-low chip select;
- returns the received frame for the SPI input register, with busy/done/overrun status for software polling.

## Interface
Parameters
- FRAME_W, 8: bits per transfer, 1..32; data taken from / returned in bits [FRAME_W-1:0].

Ports
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low; sampled on rising clk.
- tx_start  in  1  one-cycle pulse, CPU wrote the SPI output register.
- tx_data  in  32  SPI output register value; bits [FRAME_W-1:0] transmitted.
- clkdiv  in  32  SPI clock divider register; only bits [15:0] used.
- clr_overrun  in  1  one-cycle pulse, clears overrun.
- miso  in  1  serial data from slave.
- sclk  out  1  serial clock, idle low.
- mosi  out  1  serial data to slave.
- cs_n  out  1  chip select, active low.
- rx_data  out  32  last received frame, zero-extended above FRAME_W.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse, transfer complete and rx_data updated.
- overrun  out  1  sticky; tx_start arrived while busy.

## Operation
- FSM states: IDLE, SETUP, SCLK_HI, SCLK_LO, DONE.
- Half-period: H = clkdiv[15:0] + 1 clk cycles.
  - Range is 1..65536; clkdiv=0 gives H=1.
  - 17-bit counter, no overflow.
  - H is latched at start and held for the whole transfer.
- IDLE or DONE, tx_start=1:
  - latch tx_data[FRAME_W-1:0] into the shift register and latch H;
  - go to SETUP; cs_n=0, mosi=tx_data[FRAME_W-1].
- SETUP, after H cycles: sclk goes high; miso is captured into the rx shift register LSB on the same edge; go to SCLK_HI.
- SCLK_HI, after H cycles: sclk goes low; go to SCLK_LO.
  - If FRAME_W bits have been sampled, mosi is held.
  - Otherwise mosi shifts to the next bit.
- SCLK_LO, after H cycles:
  - Bits remaining: sclk goes high, miso is sampled, go to SCLK_HI.
  - Final low phase (acts as CS hold): cs_n goes high, rx_data loads the rx shift register, go to DONE.
- DONE, exactly 1 cycle:
  - done=1, busy=0, cs_n=1, sclk=0.
  - tx_start is accepted here as in IDLE; back-to-back frames get a 1-cycle cs_n-high gap.
  - Without tx_start, go to IDLE.
- busy=1 in SETUP, SCLK_HI and SCLK_LO only.
- tx_start while busy:
  - the request is ignored and the transfer continues unchanged;
  - overrun=1 from the next cycle.
- clr_overrun clears overrun next cycle. If tx_start-while-busy and clr_overrun occur in the same cycle, set wins.
- mosi returns to 0 in IDLE. tx_data and clkdiv changes during a transfer have no effect.

## Timing
- Reset values: sclk=0, mosi=0, cs_n=1, rx_data=0, busy=0, done=0, overrun=0; state IDLE.
- Reset mid-transfer: the next rising edge forces reset values. The frame is aborted, done is not pulsed, and rx_data reads 0.
- tx_start sampled high in cycle 0 (IDLE):
  - cs_n=0 and busy=1 for cycles 1 .. H*(2*FRAME_W+1);
  - done=1 and cs_n=1 in cycle H*(2*FRAME_W+1)+1.
- Rising SCLK edge k (k=0..FRAME_W-1) is at cycle 1 + H*(2k+1).
  - mosi is stable ≥H cycles before and after each rising edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset/idle: hold rst=0 for 3 cycles, release -> sclk=0, cs_n=1, mosi=0, busy=0, rx_data=0; no activity for 20 cycles with tx_start=0.
- Basic loopback: FRAME_W=8, clkdiv=0, miso tied to mosi, tx_data=0x000000A5, start in cycle 0 -> 8 sclk pulses, mosi bit sequence 1,0,1,0,0,1,0,1 on rising edges, done in cycle 18, rx_data=0x000000A5.
- Divider: clkdiv=3 (H=4), slave model returns 0x3C -> each sclk high/low phase lasts 4 cycles, cs_n low 68 cycles, rx_data=0x0000003C; clkdiv changed to 0 mid-frame does not alter phase length.
- Overrun: pulse tx_start in cycle 5 of a busy transfer -> frame unaffected, overrun=1 from cycle 6. Then clr_overrun and a second illegal tx_start in the same cycle -> overrun stays 1. clr_overrun alone -> 0 next cycle.
- Back-to-back: tx_start asserted in the DONE cycle -> cs_n high for exactly 1 cycle, second frame completes with correct rx_data.
- Reset mid-transfer: rst=0 in cycle 7 of a clkdiv=1 transfer -> next edge cs_n=1, sclk=0, busy=0, rx_data=0, no done pulse. A new start afterwards completes normally.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master sequencer: frames one FRAME_W-bit transfer per tx_start,
// MSB first, with a programmable half-period and busy/done/overrun status.
module spi_master_ctrl #(
   parameter int FRAME_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_start,
   input  logic [31:0] tx_data,
   input  logic [31:0] clkdiv,
   input  logic        clr_overrun,
   input  logic        miso,
   output logic        sclk,
   output logic        mosi,
   output logic        cs_n,
   output logic [31:0] rx_data,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      SCLK_HI = 3'd2,
      SCLK_LO = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [5:0] FRAME_BITS = 6'(FRAME_W);

   state_t             state_r;
   logic [16:0]        cnt_r;
   logic [16:0]        half_r;
   logic [5:0]         bit_cnt_r;
   logic [FRAME_W-1:0] tx_shift_r;
   logic [FRAME_W-1:0] rx_shift_r;

   logic               phase_end_s;
   logic [FRAME_W:0]   rx_wide_s;
   logic [FRAME_W:0]   tx_wide_s;
   logic [FRAME_W-1:0] rx_next_s;
   logic [FRAME_W-1:0] tx_next_s;
   logic               unused_s;

   assign phase_end_s = ((cnt_r + 17'd1) == half_r);
   assign unused_s    = ^{clkdiv[31:16], tx_data, rx_wide_s[FRAME_W], tx_wide_s[FRAME_W]};

   // Next values of the shift registers; the wide forms keep FRAME_W=1 legal.
   always_comb begin
      rx_wide_s = {rx_shift_r, miso};
      tx_wide_s = {tx_shift_r, 1'b0};
      rx_next_s = rx_wide_s[FRAME_W-1:0];
      tx_next_s = tx_wide_s[FRAME_W-1:0];
   end

   // Transfer sequencer with registered bus and status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= IDLE;
         cnt_r      <= 17'd0;
         half_r     <= 17'd1;
         bit_cnt_r  <= 6'd0;
         tx_shift_r <= '0;
         rx_shift_r <= '0;
         sclk       <= 1'b0;
         mosi       <= 1'b0;
         cs_n       <= 1'b1;
         rx_data    <= 32'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         done <= 1'b0;

         // A request while busy is dropped but remembered; setting beats clearing.
         if (tx_start && busy) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end else begin
            overrun <= overrun;
         end

         case (state_r)
            IDLE, DONE: begin
               if (tx_start) begin
                  tx_shift_r <= tx_data[FRAME_W-1:0];
                  half_r     <= {1'b0, clkdiv[15:0]} + 17'd1;
                  cnt_r      <= 17'd0;
                  bit_cnt_r  <= 6'd0;
                  cs_n       <= 1'b0;
                  busy       <= 1'b1;
                  sclk       <= 1'b0;
                  mosi       <= tx_data[FRAME_W-1];
                  state_r    <= SETUP;
               end else begin
                  cs_n    <= 1'b1;
                  busy    <= 1'b0;
                  sclk    <= 1'b0;
                  mosi    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            SETUP: begin
               if (phase_end_s) begin
                  cnt_r      <= 17'd0;
                  sclk       <= 1'b1;
                  rx_shift_r <= rx_next_s;
                  bit_cnt_r  <= bit_cnt_r + 6'd1;
                  state_r    <= SCLK_HI;
               end else begin
                  cnt_r <= cnt_r + 17'd1;
               end
            end
            SCLK_HI: begin
               if (phase_end_s) begin
                  cnt_r   <= 17'd0;
                  sclk    <= 1'b0;
                  state_r <= SCLK_LO;
                  // After the last sample mosi holds its final bit.
                  if (bit_cnt_r != FRAME_BITS) begin
                     tx_shift_r <= tx_next_s;
                     mosi       <= tx_next_s[FRAME_W-1];
                  end else begin
                     mosi <= mosi;
                  end
               end else begin
                  cnt_r <= cnt_r + 17'd1;
               end
            end
            SCLK_LO: begin
               if (phase_end_s) begin
                  cnt_r <= 17'd0;
                  if (bit_cnt_r == FRAME_BITS) begin
                     cs_n    <= 1'b1;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     rx_data <= 32'(rx_shift_r);
                     state_r <= DONE;
                  end else begin
                     sclk       <= 1'b1;
                     rx_shift_r <= rx_next_s;
                     bit_cnt_r  <= bit_cnt_r + 6'd1;
                     state_r    <= SCLK_HI;
                  end
               end else begin
                  cnt_r <= cnt_r + 17'd1;
               end
            end
            default: begin
               cs_n    <= 1'b1;
               busy    <= 1'b0;
               sclk    <= 1'b0;
               mosi    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed and randomized bench for spi_master_ctrl; expected waveforms are
// computed per cycle from the half-period arithmetic of a mode-0 frame.
module tb_spi_master_ctrl;

   localparam int FW = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_start;
   logic [31:0] tx_data;
   logic [31:0] clkdiv;
   logic        clr_overrun;
   logic        miso;
   logic        sclk;
   logic        mosi;
   logic        cs_n;
   logic [31:0] rx_data;
   logic        busy;
   logic        done;
   logic        overrun;

   int          n_total = 0;
   int          n_pass  = 0;
   int          n_fail  = 0;
   logic        ovr_exp;
   logic [31:0] rx_exp;

   always #5 clk = ~clk;

   spi_master_ctrl #(.FRAME_W(FW)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .clkdiv      (clkdiv),
      .clr_overrun (clr_overrun),
      .miso        (miso),
      .sclk        (sclk),
      .mosi        (mosi),
      .cs_n        (cs_n),
      .rx_data     (rx_data),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Idle cycles: bus quiet, status stable.
   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk($sformatf("%s i%0d pins", tag, i), {27'd0, cs_n, sclk, mosi, busy, done}, 32'h10);
         chk($sformatf("%s i%0d rx", tag, i), rx_data, rx_exp);
         chk($sformatf("%s i%0d ovr", tag, i), {31'd0, overrun}, {31'd0, ovr_exp});
      end
   endtask

   // One frame started in cycle 0; returns in the done cycle (or after a reset).
   // Optional events, by cycle number (0 = none): illegal start, illegal start plus
   // clear, clear alone, divider/data change, reset.
   task automatic run_frame(input string tag, input logic [31:0] tx, input logic [15:0] div,
                            input bit loopback, input logic [7:0] sw,
                            input int ovr_c, input int both_c, input int clr_c,
                            input int chg_c, input int rst_c);
      int       h, len, c, p, k;
      logic [7:0] txb;
      logic     cs_e, sclk_e, mosi_e, busy_e, done_e, ovr_next, start_now, clr_now;
      bit       fin;
      h   = int'(div) + 1;
      len = h * (2 * FW + 1);
      txb = tx[7:0];
      tx_data  = tx;
      clkdiv   = {16'($urandom), div};
      miso     = 1'b0;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      fin = 1'b0;
      c   = 1;
      while (!fin) begin
         p      = (c - 1) / h;
         k      = (p / 2 > FW - 1) ? FW - 1 : p / 2;
         cs_e   = (c > len);
         busy_e = (c <= len);
         sclk_e = (c <= len) && (p % 2 == 1);
         mosi_e = txb[FW-1-k];
         done_e = (c == len + 1);
         if (done_e) rx_exp = loopback ? {24'd0, txb} : {24'd0, sw};
         chk($sformatf("%s c%0d cs/sclk/mosi/busy/done", tag, c),
             {27'd0, cs_n, sclk, mosi, busy, done},
             {27'd0, cs_e, sclk_e, mosi_e, busy_e, done_e});
         chk($sformatf("%s c%0d rx", tag, c), rx_data, rx_exp);
         chk($sformatf("%s c%0d ovr", tag, c), {31'd0, overrun}, {31'd0, ovr_exp});
         if (done_e) begin
            fin = 1'b1;
         end else begin
            miso        = loopback ? mosi : sw[FW-1-k];
            start_now   = (c == ovr_c) || (c == both_c);
            clr_now     = (c == both_c) || (c == clr_c);
            tx_start    = start_now;
            clr_overrun = clr_now;
            if (c == chg_c) begin
               clkdiv  = 32'd0;
               tx_data = ~tx;
            end
            if (c == rst_c) rst = 1'b0;
            ovr_next = (start_now && busy_e) ? 1'b1 : (clr_now ? 1'b0 : ovr_exp);
            @(posedge clk); #1;
            tx_start    = 1'b0;
            clr_overrun = 1'b0;
            ovr_exp     = ovr_next;
            if (c == rst_c) begin
               rst     = 1'b1;
               ovr_exp = 1'b0;
               rx_exp  = 32'd0;
               chk($sformatf("%s reset pins", tag), {27'd0, cs_n, sclk, mosi, busy, done}, 32'h10);
               chk($sformatf("%s reset rx", tag), rx_data, 32'd0);
               chk($sformatf("%s reset ovr", tag), {31'd0, overrun}, 32'd0);
               fin = 1'b1;
            end
            c++;
         end
      end
   endtask

   initial begin
      logic [31:0] r_tx;
      logic [15:0] r_div;
      logic [7:0]  r_sw;
      bit          r_lb;

      rst         = 1'b0;
      tx_start    = 1'b0;
      clr_overrun = 1'b0;
      miso        = 1'b0;
      tx_data     = 32'd0;
      clkdiv      = 32'd0;
      ovr_exp     = 1'b0;
      rx_exp      = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("reset pins", {27'd0, cs_n, sclk, mosi, busy, done}, 32'h10);
      chk("reset rx", rx_data, 32'd0);
      chk("reset ovr", {31'd0, overrun}, 32'd0);
      idle("quiet", 20);

      run_frame("loop_a5", 32'h0000_00A5, 16'd0, 1'b1, 8'h00, 0, 0, 0, 0, 0);
      chk("loop_a5 rx", rx_data, 32'h0000_00A5);
      idle("after_a5", 2);

      run_frame("div3", 32'h0000_0011, 16'd3, 1'b0, 8'h3C, 0, 0, 0, 10, 0);
      chk("div3 rx", rx_data, 32'h0000_003C);
      idle("after_div3", 2);

      run_frame("ovr", 32'h0000_005A, 16'd1, 1'b0, 8'hC3, 5, 9, 14, 0, 0);
      idle("after_ovr", 2);

      run_frame("b2b1", 32'h0000_0096, 16'd1, 1'b0, 8'h81, 0, 0, 0, 0, 0);
      run_frame("b2b2", 32'h0000_0069, 16'd2, 1'b0, 8'h7E, 0, 0, 0, 0, 0);
      idle("after_b2b", 2);

      run_frame("rst_mid", 32'h0000_00F0, 16'd1, 1'b0, 8'h55, 0, 0, 0, 0, 7);
      idle("after_rst", 3);
      run_frame("post_rst", 32'h0000_000F, 16'd1, 1'b1, 8'h00, 0, 0, 0, 0, 0);
      idle("after_post", 1);

      for (int i = 0; i < 6; i++) begin
         r_tx  = $urandom;
         r_div = 16'($urandom_range(0, 4));
         r_sw  = 8'($urandom);
         r_lb  = ($urandom_range(0, 1) == 1);
         run_frame($sformatf("rand%0d", i), r_tx, r_div, r_lb, r_sw, 0, 0, 0, 0, 0);
         idle($sformatf("rand%0d_idle", i), 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
